// File: rtl/instr_register_mc_if.sv
// Bus bundle for instr_register_mc: write request/handshake and registered read port.
// The stimulus side uses the master modport, the register file the slave modport.
interface instr_register_mc_if #(
    parameter int OP_W  = 32,
    parameter int DEPTH = 32
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic                  load_en;
    logic                  load_ready;
    logic [2:0]            opcode;
    logic [OP_W-1:0]       operand_a;
    logic [OP_W-1:0]       operand_b;
    logic [ADDR_W-1:0]     write_pointer;
    logic [ADDR_W-1:0]     read_pointer;
    logic [3+4*OP_W-1:0]   instruction_word;
    logic                  read_valid;

    modport master (
        output load_en, opcode, operand_a, operand_b, write_pointer, read_pointer,
        input  load_ready, instruction_word, read_valid
    );

    modport slave (
        input  load_en, opcode, operand_a, operand_b, write_pointer, read_pointer,
        output load_ready, instruction_word, read_valid
    );
endinterface

// File: rtl/instr_register_mc.sv
// Parameterised instruction register file with a multi-cycle restoring divider for DIV/MOD.
// Optional one-cycle div_by_zero flag when INSTR_REG_DIVZ_FLAG_EN is defined.
//
// state     | meaning
// ST_IDLE   | accepting writes; opcodes 0-5 written on the accept edge
// ST_DIVIDE | one quotient bit per cycle on operand magnitudes, OP_W cycles
// ST_WRITE  | sign fix-up, entry written, back to ST_IDLE
module instr_register_mc #(
    parameter int OP_W  = 32,
    parameter int DEPTH = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    instr_register_mc_if.slave bus
`ifdef INSTR_REG_DIVZ_FLAG_EN
    ,
    output logic               div_by_zero
`endif
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int RES_W  = 2 * OP_W;
    localparam int WORD_W = 3 + 4 * OP_W;
    localparam int CNT_W  = $clog2(OP_W);
    localparam logic [ADDR_W:0]  DEPTH_C  = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OP_W - 1);

    localparam logic [2:0] OPC_ZERO  = 3'd0;
    localparam logic [2:0] OPC_PASSA = 3'd1;
    localparam logic [2:0] OPC_PASSB = 3'd2;
    localparam logic [2:0] OPC_ADD   = 3'd3;
    localparam logic [2:0] OPC_SUB   = 3'd4;
    localparam logic [2:0] OPC_MULT  = 3'd5;
    localparam logic [2:0] OPC_DIV   = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIVIDE,
        ST_WRITE
    } state_t;

    state_t              state;
    logic                load_ready_q;

    logic [2:0]          mem_opc [DEPTH];
    logic [OP_W-1:0]     mem_a   [DEPTH];
    logic [OP_W-1:0]     mem_b   [DEPTH];
    logic [RES_W-1:0]    mem_res [DEPTH];
    logic [DEPTH-1:0]    mem_vld;

    logic [2:0]          div_opc;
    logic [OP_W-1:0]     div_a;
    logic [OP_W-1:0]     div_b;
    logic [ADDR_W-1:0]   div_ptr;
    logic                div_ok;
    logic                div_zero;
    logic                div_neg_q;
    logic                div_neg_r;
    logic [CNT_W-1:0]    div_cnt;
    logic [OP_W-1:0]     div_rem;
    logic [OP_W-1:0]     div_quo;
    logic [OP_W-1:0]     div_den;

    logic [WORD_W-1:0]   iw_q;
    logic                rv_q;

    logic                wr_in_range;
    logic                rd_in_range;
    logic [RES_W-1:0]    ext_a;
    logic [RES_W-1:0]    ext_b;
    logic [RES_W-1:0]    fast_res;
    logic [OP_W-1:0]     mag_a;
    logic [OP_W-1:0]     mag_b;
    logic [OP_W:0]       trial;
    logic                trial_ge;
    logic [OP_W-1:0]     trial_sub;
    logic [RES_W-1:0]    q_ext;
    logic [RES_W-1:0]    r_ext;
    logic [RES_W-1:0]    div_res;

    assign wr_in_range = {1'b0, bus.write_pointer} < DEPTH_C;
    assign rd_in_range = {1'b0, bus.read_pointer} < DEPTH_C;

    assign ext_a = {{OP_W{bus.operand_a[OP_W-1]}}, bus.operand_a};
    assign ext_b = {{OP_W{bus.operand_b[OP_W-1]}}, bus.operand_b};

    always_comb begin
        fast_res = '0;
        case (bus.opcode)
            OPC_ZERO:  fast_res = '0;
            OPC_PASSA: fast_res = ext_a;
            OPC_PASSB: fast_res = ext_b;
            OPC_ADD:   fast_res = ext_a + ext_b;
            OPC_SUB:   fast_res = ext_a - ext_b;
            OPC_MULT:  fast_res = ext_a * ext_b;
            default:   fast_res = '0;
        endcase
    end

    // Magnitude of the most negative operand is still representable as unsigned OP_W.
    assign mag_a = bus.operand_a[OP_W-1] ? -bus.operand_a : bus.operand_a;
    assign mag_b = bus.operand_b[OP_W-1] ? -bus.operand_b : bus.operand_b;

    // Restoring step: dividend bits shift out of div_quo while quotient bits shift in.
    assign trial     = {div_rem, div_quo[OP_W-1]};
    assign trial_ge  = trial >= {1'b0, div_den};
    assign trial_sub = trial[OP_W-1:0] - div_den;

    assign q_ext = {{OP_W{1'b0}}, div_quo};
    assign r_ext = {{OP_W{1'b0}}, div_rem};

    always_comb begin
        div_res = '0;
        if (div_zero) begin
            div_res = '0;
        end else if (div_opc == OPC_DIV) begin
            div_res = div_neg_q ? -q_ext : q_ext;
        end else begin
            div_res = div_neg_r ? -r_ext : r_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            load_ready_q <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                mem_opc[i] <= '0;
                mem_a[i]   <= '0;
                mem_b[i]   <= '0;
                mem_res[i] <= '0;
            end
            mem_vld   <= '0;
            div_opc   <= '0;
            div_a     <= '0;
            div_b     <= '0;
            div_ptr   <= '0;
            div_ok    <= 1'b0;
            div_zero  <= 1'b0;
            div_neg_q <= 1'b0;
            div_neg_r <= 1'b0;
            div_cnt   <= '0;
            div_rem   <= '0;
            div_quo   <= '0;
            div_den   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.load_en) begin
                        if (bus.opcode >= OPC_DIV) begin
                            div_opc      <= bus.opcode;
                            div_a        <= bus.operand_a;
                            div_b        <= bus.operand_b;
                            div_ptr      <= bus.write_pointer;
                            div_ok       <= wr_in_range;
                            div_zero     <= (bus.operand_b == '0);
                            div_neg_q    <= bus.operand_a[OP_W-1] ^ bus.operand_b[OP_W-1];
                            div_neg_r    <= bus.operand_a[OP_W-1];
                            div_cnt      <= CNT_LAST;
                            div_rem      <= '0;
                            div_quo      <= mag_a;
                            div_den      <= mag_b;
                            load_ready_q <= 1'b0;
                            state        <= ST_DIVIDE;
                        end else if (wr_in_range) begin
                            mem_opc[bus.write_pointer] <= bus.opcode;
                            mem_a[bus.write_pointer]   <= bus.operand_a;
                            mem_b[bus.write_pointer]   <= bus.operand_b;
                            mem_res[bus.write_pointer] <= fast_res;
                            mem_vld[bus.write_pointer] <= 1'b1;
                        end
                    end
                end
                ST_DIVIDE: begin
                    if (trial_ge) begin
                        div_rem <= trial_sub;
                        div_quo <= {div_quo[OP_W-2:0], 1'b1};
                    end else begin
                        div_rem <= trial[OP_W-1:0];
                        div_quo <= {div_quo[OP_W-2:0], 1'b0};
                    end
                    if (div_cnt == '0) begin
                        state <= ST_WRITE;
                    end else begin
                        div_cnt <= div_cnt - CNT_W'(1);
                    end
                end
                ST_WRITE: begin
                    if (div_ok) begin
                        mem_opc[div_ptr] <= div_opc;
                        mem_a[div_ptr]   <= div_a;
                        mem_b[div_ptr]   <= div_b;
                        mem_res[div_ptr] <= div_res;
                        mem_vld[div_ptr] <= 1'b1;
                    end
                    load_ready_q <= 1'b1;
                    state        <= ST_IDLE;
                end
                default: begin
                    load_ready_q <= 1'b1;
                    state        <= ST_IDLE;
                end
            endcase
        end
    end

    // Memory is sampled before this edge's write lands, giving read-before-write.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            iw_q <= '0;
            rv_q <= 1'b0;
        end else if (rd_in_range) begin
            iw_q <= {mem_opc[bus.read_pointer], mem_a[bus.read_pointer],
                     mem_b[bus.read_pointer], mem_res[bus.read_pointer]};
            rv_q <= mem_vld[bus.read_pointer];
        end else begin
            iw_q <= '0;
            rv_q <= 1'b0;
        end
    end

`ifdef INSTR_REG_DIVZ_FLAG_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div_by_zero <= 1'b0;
        end else begin
            div_by_zero <= (state == ST_WRITE) && div_zero;
        end
    end
`endif

    assign bus.load_ready       = load_ready_q;
    assign bus.instruction_word = iw_q;
    assign bus.read_valid       = rv_q;

endmodule

// File: tb/tb_instr_register_mc.sv
// Testbench for instr_register_mc: arithmetic reference model plus directed literal checks.
module tb_instr_register_mc;
    localparam int W  = 32;
    localparam int D0 = 32;
    localparam int D1 = 20;
    localparam int WW = 3 + 4 * W;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    instr_register_mc_if #(.OP_W(W), .DEPTH(D0)) if0();
    instr_register_mc_if #(.OP_W(W), .DEPTH(D1)) if1();

`ifdef INSTR_REG_DIVZ_FLAG_EN
    logic dz0, dz1;
`endif

    instr_register_mc #(.OP_W(W), .DEPTH(D0)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(if0.slave)
`ifdef INSTR_REG_DIVZ_FLAG_EN
        , .div_by_zero(dz0)
`endif
    );

    instr_register_mc #(.OP_W(W), .DEPTH(D1)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(if1.slave)
`ifdef INSTR_REG_DIVZ_FLAG_EN
        , .div_by_zero(dz1)
`endif
    );

    int total = 0;
    int bad = 0;
    bit chk_on = 1'b0;

    task automatic check(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [2*W-1:0] calc(input logic [2:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        longint sa, sb, r;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            3'd0: r = 0;
            3'd1: r = sa;
            3'd2: r = sb;
            3'd3: r = sa + sb;
            3'd4: r = sa - sb;
            3'd5: r = sa * sb;
            3'd6: r = (sb == 0) ? 0 : sa / sb;
            default: r = (sb == 0) ? 0 : sa % sb;
        endcase
        return r;
    endfunction

    // Reference model for dut0: entry contents, registered read, busy window.
    logic [WW-1:0] m_word [D0];
    logic          m_vld  [D0];
    logic [WW-1:0] exp_iw;
    logic          exp_rv;
    int            busy;
    bit            pre_ready;
    logic [WW-1:0] p_word;
    logic [4:0]    p_wp;
    logic          p_dz;
    logic          exp_dz;

    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < D0; i++) begin
                m_word[i] = '0;
                m_vld[i]  = 1'b0;
            end
            exp_iw = '0;
            exp_rv = 1'b0;
            busy   = 0;
            exp_dz = 1'b0;
        end else begin
            pre_ready = (busy == 0);
            exp_iw = m_word[if0.read_pointer];
            exp_rv = m_vld[if0.read_pointer];
            exp_dz = 1'b0;
            if (busy > 0) begin
                busy--;
                if (busy == 0) begin
                    m_word[p_wp] = p_word;
                    m_vld[p_wp]  = 1'b1;
                    exp_dz       = p_dz;
                end
            end
            if (if0.load_en && pre_ready) begin
                if (if0.opcode < 3'd6) begin
                    m_word[if0.write_pointer] = {if0.opcode, if0.operand_a, if0.operand_b,
                                                 calc(if0.opcode, if0.operand_a, if0.operand_b)};
                    m_vld[if0.write_pointer]  = 1'b1;
                end else begin
                    p_word = {if0.opcode, if0.operand_a, if0.operand_b,
                              calc(if0.opcode, if0.operand_a, if0.operand_b)};
                    p_wp   = if0.write_pointer;
                    p_dz   = (if0.operand_b == '0);
                    busy   = W + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("model_word", if0.instruction_word, exp_iw);
            check("model_valid", WW'(if0.read_valid), WW'(exp_rv));
            check("model_ready", WW'(if0.load_ready), WW'(busy == 0));
`ifdef INSTR_REG_DIVZ_FLAG_EN
            check("model_divz", WW'(dz0), WW'(exp_dz));
`endif
        end
    end

    task automatic wr(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [4:0] wp);
        if0.opcode = op;
        if0.operand_a = a;
        if0.operand_b = b;
        if0.write_pointer = wp;
        if0.load_en = 1'b1;
        @(negedge clk);
        if0.load_en = 1'b0;
    endtask

    task automatic rd(input logic [4:0] addr, input logic [WW-1:0] w, input logic v,
                      input string nm);
        if0.read_pointer = addr;
        @(negedge clk);
        check(nm, if0.instruction_word, w);
        check({nm, "_valid"}, WW'(if0.read_valid), WW'(v));
    endtask

    task automatic wait_ready(input string nm);
        int n;
        n = 0;
        while (!if0.load_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!if0.load_ready) begin
            total++;
            bad++;
            $display("FAIL %s: load_ready still 0 after %0d cycles, want 1", nm, n);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int low;
        if0.load_en = 1'b0; if0.opcode = '0; if0.operand_a = '0; if0.operand_b = '0;
        if0.write_pointer = '0; if0.read_pointer = '0;
        if1.load_en = 1'b0; if1.opcode = '0; if1.operand_a = '0; if1.operand_b = '0;
        if1.write_pointer = '0; if1.read_pointer = '0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        chk_on = 1'b1;

        check("rst_ready", WW'(if0.load_ready), WW'(1'b1));
        rd(5'd5, '0, 1'b0, "rst_read5");

        wr(3'd3, 32'hFFFF_FFFD, 32'd7, 5'd0);
        rd(5'd0, {3'd3, 32'hFFFF_FFFD, 32'd7, 64'd4}, 1'b1, "add");
        wr(3'd5, 32'hFFFF_FFFC, 32'd5, 5'd1);
        rd(5'd1, {3'd5, 32'hFFFF_FFFC, 32'd5, 64'hFFFF_FFFF_FFFF_FFEC}, 1'b1, "mult");
        wr(3'd4, 32'd2, 32'd9, 5'd2);
        rd(5'd2, {3'd4, 32'd2, 32'd9, 64'hFFFF_FFFF_FFFF_FFF9}, 1'b1, "sub");

        // Back-to-back writes, then a read of the address being rewritten on the same edge.
        if0.load_en = 1'b1;
        if0.opcode = 3'd1; if0.operand_a = 32'd11; if0.operand_b = 32'd22; if0.write_pointer = 5'd7;
        @(negedge clk);
        if0.opcode = 3'd0; if0.operand_a = 32'd5; if0.operand_b = 32'd6; if0.write_pointer = 5'd8;
        @(negedge clk);
        if0.opcode = 3'd2; if0.operand_a = 32'd1; if0.operand_b = 32'd99; if0.write_pointer = 5'd7;
        if0.read_pointer = 5'd7;
        @(negedge clk);
        if0.load_en = 1'b0;
        check("rbw_old", if0.instruction_word, {3'd1, 32'd11, 32'd22, 64'd11});
        rd(5'd7, {3'd2, 32'd1, 32'd99, 64'd99}, 1'b1, "rbw_new");
        rd(5'd8, {3'd0, 32'd5, 32'd6, 64'd0}, 1'b1, "zero");

        // DIV with load_en held high through the busy window.
        if0.opcode = 3'd6; if0.operand_a = 32'hFFFF_FFF9; if0.operand_b = 32'd2;
        if0.write_pointer = 5'd3; if0.load_en = 1'b1;
        @(negedge clk);
        if0.opcode = 3'd3; if0.operand_a = 32'd1; if0.operand_b = 32'd1; if0.write_pointer = 5'd10;
        low = 0;
        while (!if0.load_ready && low < 100) begin
            if0.read_pointer = 5'(low % 8);
            @(negedge clk);
            low++;
        end
        if0.load_en = 1'b0;
        check("div_busy_cycles", WW'(low), WW'(33));
        rd(5'd3, {3'd6, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD}, 1'b1, "div");
        rd(5'd10, '0, 1'b0, "single_accept");

        wr(3'd7, 32'hFFFF_FFF9, 32'd2, 5'd5);
        wait_ready("mod_wait");
        rd(5'd5, {3'd7, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFF}, 1'b1, "mod");

        wr(3'd6, 32'd7, 32'hFFFF_FFFE, 5'd11);
        wait_ready("div_neg_wait");
        wr(3'd7, 32'd7, 32'hFFFF_FFFE, 5'd12);
        wait_ready("mod_neg_wait");

        wr(3'd6, 32'd9, 32'd0, 5'd6);
`ifdef INSTR_REG_DIVZ_FLAG_EN
        low = 0;
        repeat (40) begin
            @(negedge clk);
            if (dz0) low++;
        end
        check("divz_pulse_count", WW'(low), WW'(1));
`else
        wait_ready("div0_wait");
`endif
        rd(5'd6, {3'd6, 32'd9, 32'd0, 64'd0}, 1'b1, "div_by_0");

        for (int i = 0; i < 16; i++) begin
            if0.read_pointer = 5'(i);
            @(negedge clk);
        end

        // Reset in the middle of a divide.
        wr(3'd6, 32'd100, 32'd3, 5'd4);
        repeat (9) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("abort_ready", WW'(if0.load_ready), WW'(1'b1));
        rd(5'd4, '0, 1'b0, "abort_entry");
        rd(5'd0, '0, 1'b0, "reset_clears");
        repeat (40) @(negedge clk);
        rd(5'd4, '0, 1'b0, "abort_no_late_write");

        // DEPTH=20 instance: out-of-range write and read, last valid address.
        if1.opcode = 3'd1; if1.operand_a = 32'd5; if1.operand_b = 32'd0;
        if1.write_pointer = 5'd25; if1.load_en = 1'b1;
        @(negedge clk);
        if1.load_en = 1'b0;
        if1.read_pointer = 5'd25;
        @(negedge clk);
        check("oor_read_word", if1.instruction_word, '0);
        check("oor_read_valid", WW'(if1.read_valid), WW'(1'b0));
        if1.write_pointer = 5'd19; if1.load_en = 1'b1;
        @(negedge clk);
        if1.load_en = 1'b0;
        if1.read_pointer = 5'd19;
        @(negedge clk);
        check("last_entry_word", if1.instruction_word, {3'd1, 32'd5, 32'd0, 64'd5});
        check("last_entry_valid", WW'(if1.read_valid), WW'(1'b1));

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
